// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, default address width, icode type.
package y86_pkg;

    localparam int unsigned Y86_ADDR_W = 64;

    typedef logic [3:0] icode_t;

    localparam icode_t IHALT = 4'd0;
    localparam icode_t INOP  = 4'd1;
    localparam icode_t IJXX  = 4'd7;
    localparam icode_t ICALL = 4'd8;
    localparam icode_t IRET  = 4'd9;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer whose oldest entry is overwritten when
// full; the count saturates at DEPTH and a pop on an empty stack is ignored.
module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;

    // ptr names the next free slot; the top sits one below it (wrapping).
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == CNT_W'(0));

    // Pointer and occupancy; push wins if both are ever asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_select_ras.sv
// Fetch PC selection with registered prediction and optional return-address
// stack. Build option PC_RAS_EN: when defined, rets are predicted from the RAS
// and the W stage redirects only on a wrong prediction; otherwise every ret
// that reaches W redirects to its actual return address.
module pc_select_ras
    import y86_pkg::*;
#(
    parameter int unsigned          ADDR_W    = Y86_ADDR_W,
    parameter int unsigned          RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        f_stall,
    input  logic [3:0]                  f_icode,
    input  logic [ADDR_W-1:0]           f_valC,
    input  logic [ADDR_W-1:0]           f_valP,
    input  logic [3:0]                  m_icode,
    input  logic                        m_cnd,
    input  logic [ADDR_W-1:0]           m_valA,
    input  logic [3:0]                  w_icode,
    input  logic [ADDR_W-1:0]           w_valM,
    input  logic [ADDR_W-1:0]           w_pred_tgt,
    output logic [ADDR_W-1:0]           f_pc,
    output logic [ADDR_W-1:0]           pred_pc,
    output logic [ADDR_W-1:0]           f_pred_tgt,
    output logic                        redirect,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    logic mismatch;
    logic w_ret_fix;
    logic m_mispred;

`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;

    assign ras_push = !f_stall && (f_icode == ICALL);
    assign ras_pop  = !f_stall && (f_icode == IRET);
    assign mismatch = (w_valM != w_pred_tgt);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (f_valP),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty)
    );
`else
    logic unused_pred_tgt;

    // Without prediction every ret is treated as mispredicted.
    assign mismatch        = 1'b1;
    assign ras_count       = '0;
    assign unused_pred_tgt = ^w_pred_tgt;
`endif

    assign w_ret_fix = (w_icode == IRET) && mismatch;
    assign m_mispred = (m_icode == IJXX) && !m_cnd;

    // Fetch PC select; the W-stage instruction is older so it wins.
    always_comb begin
        f_pc     = pred_pc;
        redirect = 1'b0;
        if (w_ret_fix) begin
            f_pc     = w_valM;
            redirect = 1'b1;
        end else if (m_mispred) begin
            f_pc     = m_valA;
            redirect = 1'b1;
        end
    end

    // Next-PC prediction from the fetch-stage decode.
    always_comb begin
        f_pred_tgt = f_valP;
        case (f_icode)
            IJXX, ICALL: f_pred_tgt = f_valC;
`ifdef PC_RAS_EN
            IRET:        f_pred_tgt = ras_empty ? f_valP : ras_top;
`endif
            default:     f_pred_tgt = f_valP;
        endcase
    end

    // Predicted-PC register; a stall holds it even across a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc <= RESET_PC;
        end else if (!f_stall) begin
            pred_pc <= f_pred_tgt;
        end
    end

endmodule

// File: tb/tb_pc_select_ras.sv
// Bench for pc_select_ras: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based behavioural model.
module tb_pc_select_ras;

    localparam int unsigned AW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RPC = 64'h100;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          f_stall;
    logic [3:0]    f_icode;
    logic [AW-1:0] f_valC;
    logic [AW-1:0] f_valP;
    logic [3:0]    m_icode;
    logic          m_cnd;
    logic [AW-1:0] m_valA;
    logic [3:0]    w_icode;
    logic [AW-1:0] w_valM;
    logic [AW-1:0] w_pred_tgt;
    logic [AW-1:0] f_pc;
    logic [AW-1:0] pred_pc;
    logic [AW-1:0] f_pred_tgt;
    logic          redirect;
    logic [2:0]    ras_count;

    int n_checks = 0;
    int n_pass   = 0;

    pc_select_ras #(
        .ADDR_W    (AW),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (RPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_stall    (f_stall),
        .f_icode    (f_icode),
        .f_valC     (f_valC),
        .f_valP     (f_valP),
        .m_icode    (m_icode),
        .m_cnd      (m_cnd),
        .m_valA     (m_valA),
        .w_icode    (w_icode),
        .w_valM     (w_valM),
        .w_pred_tgt (w_pred_tgt),
        .f_pc       (f_pc),
        .pred_pc    (pred_pc),
        .f_pred_tgt (f_pred_tgt),
        .redirect   (redirect),
        .ras_count  (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_pred;
    logic [AW-1:0] m_ras[$];   // back of queue = most recent call

    function automatic logic [AW-1:0] model_tgt();
        if (f_icode == 4'd7 || f_icode == 4'd8) return f_valC;
        if (f_icode == 4'd9 && RAS_ON && m_ras.size() > 0) return m_ras[$];
        return f_valP;
    endfunction

    function automatic logic model_wfix();
        return (w_icode == 4'd9) && (!RAS_ON || (w_valM != w_pred_tgt));
    endfunction

    function automatic logic model_mfix();
        return (m_icode == 4'd7) && !m_cnd;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pred = RPC;
            m_ras.delete();
        end else if (!f_stall) begin
            logic [AW-1:0] t;
            t = model_tgt();
            if (f_icode == 4'd8) begin
                m_ras.push_back(f_valP);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (f_icode == 4'd9 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
            m_pred = t;
        end
    end

    // Every-cycle comparison, mid-cycle away from the active edge.
    always @(negedge clk) begin
        logic [AW-1:0] e_pc;
        e_pc = model_wfix() ? w_valM : (model_mfix() ? m_valA : m_pred);
        check("pred_pc", pred_pc, m_pred);
        check("f_pc", f_pc, e_pc);
        check("redirect", AW'(redirect), AW'(model_wfix() | model_mfix()));
        check("f_pred_tgt", f_pred_tgt, model_tgt());
        check("ras_count", AW'(ras_count), RAS_ON ? AW'(m_ras.size()) : AW'(0));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] valp);
        f_stall = 1'b0; f_icode = 4'd1; f_valC = '0; f_valP = valp;
        m_icode = 4'd0; m_cnd = 1'b0; m_valA = '0;
        w_icode = 4'd0; w_valM = '0; w_pred_tgt = '0;
    endtask

    task automatic async_reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("areset_pred_pc", pred_pc, RPC);
        check("areset_ras_count", AW'(ras_count), AW'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(64'h104);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_pred_pc", pred_pc, 64'h100);
        check("rst_f_pc", f_pc, 64'h100);
        check("rst_ras_count", AW'(ras_count), AW'(0));
        check("rst_redirect", AW'(redirect), AW'(0));
        cyc();

        // Taken-predicted jump then M-stage mispredict.
        f_icode = 4'd7; f_valC = 64'h40; f_valP = 64'h109;
        cyc();
        check("jxx_pred_pc", pred_pc, 64'h40);
        idle(64'h48);
        m_icode = 4'd7; m_cnd = 1'b0; m_valA = 64'h20;
        #1;
        check("mispred_f_pc", f_pc, 64'h20);
        check("mispred_redirect", AW'(redirect), AW'(1));
        cyc();

        // W-stage ret fix outranks the M-stage mispredict.
        w_icode = 4'd9; w_valM = 64'h80; w_pred_tgt = 64'h99;
        #1;
        check("prio_f_pc", f_pc, 64'h80);
        cyc();

        // Stalled call changes nothing.
        idle(64'h60);
        f_stall = 1'b1; f_icode = 4'd8; f_valC = 64'h200;
        cyc();
        check("stall_pred_pc", pred_pc, 64'h48);
        check("stall_ras_count", AW'(ras_count), AW'(0));
        idle(64'h48);

`ifdef PC_RAS_EN
        f_icode = 4'd8; f_valC = 64'h300; f_valP = 64'h30;
        cyc();
        check("call_ras_count", AW'(ras_count), AW'(1));
        check("call_pred_pc", pred_pc, 64'h300);
        f_icode = 4'd9; f_valP = 64'h301;
        #1;
        check("ret_pred_tgt", f_pred_tgt, 64'h30);
        cyc();
        check("ret_ras_count", AW'(ras_count), AW'(0));
        idle(64'h31);
        w_icode = 4'd9; w_valM = 64'h30; w_pred_tgt = 64'h30;
        #1;
        check("wret_ok_redirect", AW'(redirect), AW'(0));
        check("wret_ok_f_pc", f_pc, 64'h30);
        cyc();
        idle(64'h31);

        for (int k = 1; k <= 5; k++) begin
            f_icode = 4'd8; f_valC = 64'h500; f_valP = AW'(k * 16);
            cyc();
        end
        check("ovf_ras_count", AW'(ras_count), AW'(4));
        for (int k = 0; k < 4; k++) begin
            f_icode = 4'd9; f_valP = 64'hA00;
            #1;
            check("ovf_ret_tgt", f_pred_tgt, AW'(64'h50 - 64'(k * 16)));
            cyc();
        end
        f_icode = 4'd9; f_valP = 64'hA00;
        #1;
        check("udf_ret_tgt", f_pred_tgt, 64'hA00);
        cyc();
        check("udf_ras_count", AW'(ras_count), AW'(0));

        for (int k = 0; k < 3; k++) begin
            f_icode = 4'd8; f_valC = 64'h700; f_valP = AW'(64'h70 + 64'(k));
            cyc();
        end
        idle(64'h704);
        #1;
        check("pre_areset_ras_count", AW'(ras_count), AW'(3));
        async_reset_pulse();
`else
        f_icode = 4'd9; f_valP = 64'h18;
        #1;
        check("noras_ret_tgt", f_pred_tgt, 64'h18);
        cyc();
        idle(64'h19);
        w_icode = 4'd9; w_valM = 64'h18; w_pred_tgt = 64'h18;
        #1;
        check("noras_wret_redirect", AW'(redirect), AW'(1));
        check("noras_wret_f_pc", f_pc, 64'h18);
        cyc();
        idle(64'h19);
        f_icode = 4'd8; f_valC = 64'h700; f_valP = 64'h70;
        cyc();
        check("noras_call_pred_pc", pred_pc, 64'h700);
        idle(64'h704);
        #1;
        async_reset_pulse();
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            f_stall = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            if (r <= 2)      f_icode = 4'd8;
            else if (r <= 5) f_icode = 4'd9;
            else if (r == 6) f_icode = 4'd7;
            else if (r == 7) f_icode = 4'd1;
            else if (r == 8) f_icode = 4'd0;
            else             f_icode = 4'($urandom_range(0, 15));
            f_valC  = {$urandom(), $urandom()};
            f_valP  = {$urandom(), $urandom()};
            m_icode = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            m_cnd   = 1'($urandom_range(0, 1));
            m_valA  = {$urandom(), $urandom()};
            w_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            w_valM  = {$urandom(), $urandom()};
            w_pred_tgt = ($urandom_range(0, 1) == 0) ? w_valM : {$urandom(), $urandom()};
            cyc();
        end

        idle(64'h0);
        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
